// File: rtl/regfile_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_sequencer_pkg
// Description : Shared widths and write-back entry layout for the register
//               file write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_sequencer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : regfile_write_sequencer_pkg
`default_nettype wire

// File: rtl/regfile_write_sequencer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH x 37 synchronous write-back FIFO exposing per-entry
//               valid bits and destination addresses for hazard compares.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_write_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Push,
    input  logic [ENTRY_W-1:0]          PushEntry,
    input  logic                        Pop,
    output logic [ENTRY_W-1:0]          HeadEntry,
    output logic [CNT_W-1:0]            Count,
    output logic                        Empty,
    output logic                        Full,
    output logic [DEPTH-1:0]            ValidVec,
    output logic [DEPTH*REG_ADDR_W-1:0] AddrVec
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    assign Empty    = (r_count == '0);
    assign Full     = (r_count == CNT_W'(DEPTH));
    assign w_doPush = Push & ~Full;
    assign w_doPop  = Pop & ~Empty;

    assign HeadEntry = r_mem[r_head];
    assign Count     = r_count;
    assign ValidVec  = r_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr_flat
            assign AddrVec[gi*REG_ADDR_W +: REG_ADDR_W] = r_mem[gi][ENTRY_W-1 -: REG_ADDR_W];
        end
    endgenerate

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_doPush) begin
                r_mem[r_tail]   <= PushEntry;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_sequencer
// Description : Arbitrates load/ALU write-back requests into an in-order
//               queue driving the register file write port, with hazard flags.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_sequencer
    import regfile_write_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MemValid,
    output logic                  MemReady,
    input  logic [4:0]            MemReg,
    input  logic [31:0]           MemData,
    input  logic                  AluValid,
    output logic                  AluReady,
    input  logic [4:0]            AluReg,
    input  logic [31:0]           AluData,
    input  logic                  Freeze,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic                  Pending1,
    output logic                  Pending2,
    output logic [4:0]            WriteRegister,
    output logic [31:0]           WriteData,
    output logic                  RegWrite,
    output logic [CNT_W-1:0]      Count,
    output logic                  Empty
);

    logic                        w_full;
    logic                        w_memFire;
    logic                        w_aluFire;
    logic                        w_push;
    logic                        w_pop;
    wb_entry_t                   w_pushEntry;
    wb_entry_t                   w_headEntry;
    logic [DEPTH-1:0]            w_validVec;
    logic [DEPTH*REG_ADDR_W-1:0] w_addrVec;
    logic [DEPTH-1:0]            w_hit1;
    logic [DEPTH-1:0]            w_hit2;

    // Readies look only at registered occupancy; a same-cycle pop earns no credit.
    assign MemReady = ~w_full;
    assign AluReady = ~w_full & ~MemValid;

    assign w_memFire = MemValid & MemReady;
    assign w_aluFire = AluValid & AluReady;

    assign w_pushEntry.addr = w_memFire ? MemReg  : AluReg;
    assign w_pushEntry.data = w_memFire ? MemData : AluData;

    // Register-0 writes complete the handshake but never occupy a slot.
    assign w_push = (w_memFire | w_aluFire) & (w_pushEntry.addr != REG_ZERO);

    assign RegWrite = ~Empty & ~Freeze;
    assign w_pop    = RegWrite;

    assign WriteRegister = Empty ? '0 : w_headEntry.addr;
    assign WriteData     = Empty ? '0 : w_headEntry.data;

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_wb_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .Push      (w_push),
        .PushEntry (w_pushEntry),
        .Pop       (w_pop),
        .HeadEntry (w_headEntry),
        .Count     (Count),
        .Empty     (Empty),
        .Full      (w_full),
        .ValidVec  (w_validVec),
        .AddrVec   (w_addrVec)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            assign w_hit1[gi] = w_validVec[gi] &
                                (w_addrVec[gi*REG_ADDR_W +: REG_ADDR_W] == ReadRegister1);
            assign w_hit2[gi] = w_validVec[gi] &
                                (w_addrVec[gi*REG_ADDR_W +: REG_ADDR_W] == ReadRegister2);
        end
    endgenerate

    assign Pending1 = (ReadRegister1 != REG_ZERO) & (|w_hit1);
    assign Pending2 = (ReadRegister2 != REG_ZERO) & (|w_hit2);

endmodule : regfile_write_sequencer
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_sequencer
// Description : Directed self-checking bench for regfile_write_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sequencer;

    logic        Clk;
    logic        Reset;
    logic        MemValid, MemReady;
    logic [4:0]  MemReg;
    logic [31:0] MemData;
    logic        AluValid, AluReady;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        Freeze;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic        Pending1, Pending2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [2:0]  Count;
    logic        Empty;

    int nAsserts = 0;
    int nFails   = 0;
    int cyc      = 0;
    int maxCount = 0;

    logic [36:0] writeLog[$];
    int          logCyc[$];

    regfile_write_sequencer #(.DEPTH(4), .CNT_W(3)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .MemValid      (MemValid),
        .MemReady      (MemReady),
        .MemReg        (MemReg),
        .MemData       (MemData),
        .AluValid      (AluValid),
        .AluReady      (AluReady),
        .AluReg        (AluReg),
        .AluData       (AluData),
        .Freeze        (Freeze),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Pending1      (Pending1),
        .Pending2      (Pending2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Count         (Count),
        .Empty         (Empty)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // A write seen enabled at the falling edge lands at the following rising edge.
    always @(negedge Clk) begin
        if (!Reset && RegWrite) begin
            writeLog.push_back({WriteRegister, WriteData});
            logCyc.push_back(cyc);
        end
        if (int'(Count) > maxCount) maxCount = int'(Count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [36:0] logAt(input int i);
        if (i < writeLog.size()) return writeLog[i];
        return '1;
    endfunction

    function automatic int cycAt(input int i);
        if (i < logCyc.size()) return logCyc[i];
        return -100;
    endfunction

    initial begin
        logic accepted;

        Reset = 1'b1; MemValid = 0; MemReg = 0; MemData = 0;
        AluValid = 0; AluReg = 0; AluData = 0; Freeze = 0;
        ReadRegister1 = 0; ReadRegister2 = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        checkEq("rstCount", Count, 0);
        checkEq("rstEmpty", Empty, 1);
        checkEq("rstRegWrite", RegWrite, 0);
        checkEq("rstWriteRegister", WriteRegister, 0);
        checkEq("rstWriteData", WriteData, 0);
        checkEq("rstMemReady", MemReady, 1);
        checkEq("rstAluReady", AluReady, 1);

        // Single load write, empty queue
        writeLog.delete(); logCyc.delete();
        MemValid = 1; MemReg = 5; MemData = 32'hDEADBEEF;
        tick();
        MemValid = 0;
        #1;
        checkEq("singleRegWrite", RegWrite, 1);
        checkEq("singleWriteRegister", WriteRegister, 5);
        checkEq("singleWriteData", WriteData, 32'hDEADBEEF);
        checkEq("singleCount", Count, 1);
        tick();
        checkEq("singleRegWriteAfter", RegWrite, 0);
        checkEq("singleEmptyAfter", Empty, 1);
        checkEq("singleLogSize", writeLog.size(), 1);
        checkEq("singleLog0", logAt(0), {5'd5, 32'hDEADBEEF});

        // Simultaneous requests: load wins, ALU follows
        writeLog.delete(); logCyc.delete();
        MemValid = 1; MemReg = 3; MemData = 32'h1;
        AluValid = 1; AluReg = 4; AluData = 32'h2;
        #1;
        checkEq("arbMemReady", MemReady, 1);
        checkEq("arbAluReady", AluReady, 0);
        tick();
        MemValid = 0;
        #1;
        checkEq("arbAluReadyNext", AluReady, 1);
        tick();
        AluValid = 0;
        tick();
        tick();
        checkEq("arbLogSize", writeLog.size(), 2);
        checkEq("arbLog0", logAt(0), {5'd3, 32'h1});
        checkEq("arbLog1", logAt(1), {5'd4, 32'h2});
        checkEq("arbConsecutive", cycAt(1) - cycAt(0), 1);

        // Freeze while filling, hazard flags, then resume
        writeLog.delete(); logCyc.delete();
        Freeze = 1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                MemValid = 1; MemReg = 5'(7 + i); MemData = 32'h700 + i;
            end else begin
                MemValid = 0; AluValid = 1; AluReg = 5'(7 + i); AluData = 32'h700 + i;
            end
            tick();
            MemValid = 0; AluValid = 0;
        end
        ReadRegister1 = 9; ReadRegister2 = 11;
        #1;
        checkEq("frzCount", Count, 4);
        checkEq("frzMemReady", MemReady, 0);
        checkEq("frzAluReady", AluReady, 0);
        checkEq("frzRegWrite", RegWrite, 0);
        checkEq("frzPending1", Pending1, 1);
        checkEq("frzPending2", Pending2, 0);
        MemValid = 1; MemReg = 12; MemData = 32'hBAD;
        tick();
        MemValid = 0;
        #1;
        checkEq("frzFullHold", Count, 4);
        Freeze = 0; ReadRegister1 = 7;
        #1;
        checkEq("frzResumeRegWrite", RegWrite, 1);
        checkEq("frzHeadPending", Pending1, 1);
        repeat (4) tick();
        checkEq("frzDrainEmpty", Empty, 1);
        checkEq("frzLogSize", writeLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkEq($sformatf("frzLog%0d", i), logAt(i), {5'(7 + i), 32'h700 + i});
        end
        checkEq("frzConsecutive", cycAt(3) - cycAt(0), 3);

        // Register-0 request is dropped
        writeLog.delete(); logCyc.delete();
        ReadRegister1 = 0; ReadRegister2 = 0;
        AluValid = 1; AluReg = 0; AluData = 32'hFFFFFFFF;
        #1;
        checkEq("r0AluReady", AluReady, 1);
        tick();
        AluValid = 0;
        #1;
        checkEq("r0Count", Count, 0);
        checkEq("r0Empty", Empty, 1);
        checkEq("r0RegWrite", RegWrite, 0);
        checkEq("r0Pending1", Pending1, 0);
        tick();
        checkEq("r0LogSize", writeLog.size(), 0);

        // Wrap: ten pushes with Freeze toggling every three cycles
        writeLog.delete(); logCyc.delete();
        maxCount = 0;
        Freeze = 1;
        begin
            int fc;
            fc = 0;
            for (int i = 0; i < 10; i++) begin
                accepted = 0;
                for (int t = 0; t < 40 && !accepted; t++) begin
                    if (i % 2 == 0) begin
                        MemValid = 1; MemReg = 5'(11 + i); MemData = 32'hA000 + i;
                    end else begin
                        AluValid = 1; AluReg = 5'(11 + i); AluData = 32'hA000 + i;
                    end
                    #1;
                    if ((i % 2 == 0) ? MemReady : AluReady) accepted = 1;
                    tick();
                    fc++;
                    Freeze = ((fc / 3) % 2 == 0);
                end
                MemValid = 0; AluValid = 0;
                checkEq($sformatf("wrapAccept%0d", i), accepted, 1);
            end
        end
        Freeze = 0;
        for (int t = 0; t < 20 && !Empty; t++) tick();
        checkEq("wrapEmpty", Empty, 1);
        checkEq("wrapLogSize", writeLog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            checkEq($sformatf("wrapLog%0d", i), logAt(i), {5'(11 + i), 32'hA000 + i});
        end
        checkEq("wrapMaxCount", (maxCount <= 4), 1);

        // Reset mid-drain with two entries queued
        writeLog.delete(); logCyc.delete();
        Freeze = 1;
        MemValid = 1; MemReg = 20; MemData = 32'h20;
        tick();
        MemValid = 0; AluValid = 1; AluReg = 21; AluData = 32'h21;
        tick();
        AluValid = 0;
        #1;
        checkEq("rstMidCount", Count, 2);
        Freeze = 0;
        #1;
        checkEq("rstMidRegWriteBefore", RegWrite, 1);
        #1 Reset = 1;
        #1;
        checkEq("rstMidRegWrite", RegWrite, 0);
        checkEq("rstMidCount0", Count, 0);
        checkEq("rstMidEmpty", Empty, 1);
        checkEq("rstMidWriteRegister", WriteRegister, 0);
        checkEq("rstMidWriteData", WriteData, 0);
        tick();
        Reset = 0;
        #1;
        checkEq("rstMidMemReady", MemReady, 1);
        checkEq("rstMidAluReady", AluReady, 1);
        tick();
        checkEq("rstMidLogSize", writeLog.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule : tb_regfile_write_sequencer
`default_nettype wire

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Initiator side of the register file's single synchronous write port.
- Accepts write-back requests from two producers: the ALU result path and the load/memory path. Each uses a valid/ready handshake.
- Buffers accepted requests in a small in-order queue and drives WriteRegister/WriteData/RegWrite, at most one write per clock.
- Reports per-read-port pending-write hazards to decode.
- Freeze input holds off all register writes so a debug snapshot of the register file's full output bus stays coherent.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- CNT_W, 3, width of Count; must equal clog2(DEPTH+1).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- MemValid  in  1  load path presents a write request.
- MemReady  out  1  load request accepted this cycle when MemValid & MemReady.
- MemReg  in  5  destination register, load path.
- MemData  in  32  write data, load path.
- AluValid  in  1  ALU path presents a write request.
- AluReady  out  1  ALU request accepted this cycle when AluValid & AluReady.
- AluReg  in  5  destination register, ALU path.
- AluData  in  32  write data, ALU path.
- Freeze  in  1  high: suppress register writes and queue pops.
- ReadRegister1  in  5  decode read address 1, for the hazard check.
- ReadRegister2  in  5  decode read address 2, for the hazard check.
- Pending1  out  1  queue holds a write to ReadRegister1.
- Pending2  out  1  queue holds a write to ReadRegister2.
- WriteRegister  out  5  register file write address.
- WriteData  out  32  register file write data.
- RegWrite  out  1  register file write enable.
- Count  out  CNT_W  occupied queue entries.
- Empty  out  1  Count==0.

Behaviour:
- Reset (async, immediate): queue cleared, head/tail pointers = 0, Count=0, Empty=1, RegWrite=0, WriteRegister=0, WriteData=0, Pending1=Pending2=0.
- Ready:
  - MemReady = (Count<DEPTH).
  - AluReady = (Count<DEPTH) & ~MemValid. The load path has fixed priority.
  - Ready depends only on registered Count: no credit is given for a same-cycle pop.
- Accept: at most one push per cycle. The winning request is written at the tail on the posedge.
- Register-0 requests complete the handshake normally but are discarded: no enqueue, Count unchanged, never written.
- Drain: RegWrite = ~Empty & ~Freeze, combinational from registered state. WriteRegister/WriteData = head entry, or 0 when Empty.
- Pop: on any posedge where RegWrite=1, the register file captures the head and the head pointer advances.
- Latency: request accepted at edge N with an empty queue and Freeze low → RegWrite high during cycle N+1 → value in the register file at edge N+1. No same-cycle bypass.
- Ordering: strict FIFO across both sources; acceptance order is write order.
- Simultaneous push and pop: Count unchanged; legal at any occupancy below DEPTH.
- Full (Count==DEPTH): both readies low. A pop this cycle lowers Count, and readies rise the following cycle.
- Pointers: wrap modulo DEPTH.
- Freeze:
  - Takes effect combinationally on RegWrite.
  - Pushes continue until full.
  - Queue contents are retained.
  - Deassertion resumes draining in order, one entry per cycle.
- Pending1: high iff ReadRegister1≠0 and any valid entry's address equals ReadRegister1. Pending2 likewise. Combinational over valid entries only. The head entry being written this cycle still counts as pending.
- Reset mid-drain or mid-handshake: queue discarded, RegWrite drops immediately, readies high once Reset deasserts.

Decomposition:
- Shared constants in the common definitions include: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0. Entry layout is {addr[4:0], data[31:0]}, 37 bits.
- One sub-module: wb_fifo. It is a parameterised DEPTH×37 synchronous FIFO with push/pop, Count, Empty, Full, and a flattened entry/valid vector for the hazard comparators.
- The top level holds the arbitration, register-0 filtering, Freeze gating and Pending compare logic.

Test Plan:
- Reset mid-stream with 2 entries queued → RegWrite=0 within the same cycle; Count=0, Empty=1, WriteRegister=0, WriteData=0, both readies high after release.
- MemValid, MemReg=5, MemData=0xDEADBEEF at edge N, queue empty → cycle N+1: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; cycle N+2: RegWrite=0, Empty=1.
- MemValid(reg 3, 0x1) and AluValid(reg 4, 0x2) in the same cycle → MemReady=1, AluReady=0; ALU accepted next cycle; register file sees reg3=0x1 and then reg4=0x2 on consecutive edges.
- Freeze=1 while pushing regs 7, 8, 9, 10 → Count=4, MemReady=AluReady=0, RegWrite=0; ReadRegister1=9 gives Pending1=1, ReadRegister2=11 gives Pending2=0. Drop Freeze → four writes 7, 8, 9, 10 on four consecutive edges.
- AluValid with AluReg=0, AluData=0xFFFFFFFF → handshake completes, Count stays 0, RegWrite never asserted; ReadRegister1=0 gives Pending1=0.
- Wrap: 10 back-to-back pushes with DEPTH=4, Freeze toggled every 3 cycles → all 10 writes in order, no loss or duplication; Count never exceeds 4.
